// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the write-back store buffer.
package store_buffer_pkg;
   localparam int SB_LEN_DATA = 32;
   localparam int SB_DEPTH    = 4;

   // Owner of the single data-memory port in a given cycle.
   typedef enum logic [1:0] {
      PORT_IDLE,
      PORT_DRAIN,
      PORT_LOAD
   } port_op_e;
endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage request/response and data-memory port signals of the store buffer.
interface store_buffer_if #(
   parameter int LEN_DATA = store_buffer_pkg::SB_LEN_DATA
);
   logic                st_req;
   logic                ld_req;
   logic [LEN_DATA-1:0] adr;
   logic [LEN_DATA-1:0] wdata;
   logic [LEN_DATA-1:0] rdata;
   logic                stall;
   logic                empty;
   logic                mem_write;
   logic                mem_read;
   logic [LEN_DATA-1:0] mem_adr;
   logic [LEN_DATA-1:0] mem_data;
   logic [LEN_DATA-1:0] mem_out;

   modport slave (
      input  st_req, ld_req, adr, wdata, mem_out,
      output rdata, stall, empty, mem_write, mem_read, mem_adr, mem_data
   );

   modport master (
      output st_req, ld_req, adr, wdata, mem_out,
      input  rdata, stall, empty, mem_write, mem_read, mem_adr, mem_data
   );
endinterface

// File: rtl/store_buffer_sb_match.sv
// Combinational address matcher returning the data of the youngest valid matching entry.
module sb_match #(
   parameter  int LEN_DATA = 32,
   parameter  int DEPTH    = 4,
   localparam int PW       = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]               valid_i,
   input  logic [DEPTH-1:0][LEN_DATA-1:0] adr_i,
   input  logic [DEPTH-1:0][LEN_DATA-1:0] data_i,
   input  logic [PW-1:0]                  head_i,
   input  logic [LEN_DATA-1:0]            req_adr_i,
   output logic                           hit_o,
   output logic [LEN_DATA-1:0]            hit_data_o
);
   logic [PW-1:0] idx;

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      idx        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + PW'(k);
         if (valid_i[idx] && adr_i[idx] == req_adr_i) begin
            hit_o      = 1'b1;
            hit_data_o = data_i[idx];
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// Circular store queue with load forwarding and a load-first data-memory port arbiter.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter  int LEN_DATA = SB_LEN_DATA,
   parameter  int DEPTH    = SB_DEPTH,
   localparam int PW       = $clog2(DEPTH),
   localparam int CW       = PW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   store_buffer_if.slave sb
);
   logic [DEPTH-1:0]               valid_q, valid_d;
   logic [DEPTH-1:0][LEN_DATA-1:0] adr_q, adr_d;
   logic [DEPTH-1:0][LEN_DATA-1:0] data_q, data_d;
   logic [PW-1:0]                  head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]                  count_q, count_d;

   logic                hit, ld_miss, full, st_acc, drain;
   logic [LEN_DATA-1:0] hit_data;
   port_op_e            port_op;

   sb_match #(.LEN_DATA(LEN_DATA), .DEPTH(DEPTH)) u_match (
      .valid_i    (valid_q),
      .adr_i      (adr_q),
      .data_i     (data_q),
      .head_i     (head_q),
      .req_adr_i  (sb.adr),
      .hit_o      (hit),
      .hit_data_o (hit_data)
   );

   // A missing load blocks the drain even when paired with a store, so the
   // port stays free for the retried load.
   assign ld_miss = sb.ld_req & ~hit;
   assign full    = (count_q == CW'(DEPTH));
   assign st_acc  = sb.st_req & ~full;
   assign drain   = (count_q != '0) & ~ld_miss;

   always_comb begin
      port_op = PORT_IDLE;
      if (drain)                       port_op = PORT_DRAIN;
      else if (ld_miss && !sb.st_req)  port_op = PORT_LOAD;
   end

   always_comb begin
      sb.mem_write = 1'b0;
      sb.mem_read  = 1'b0;
      sb.mem_adr   = '0;
      sb.mem_data  = '0;
      case (port_op)
         PORT_DRAIN: begin
            sb.mem_write = 1'b1;
            sb.mem_adr   = adr_q[head_q];
            sb.mem_data  = data_q[head_q];
         end
         PORT_LOAD: begin
            sb.mem_read = 1'b1;
            sb.mem_adr  = sb.adr;
         end
         default: ;
      endcase
   end

   assign sb.rdata = (sb.ld_req && !sb.st_req) ? (hit ? hit_data : sb.mem_out) : '0;
   assign sb.stall = sb.st_req & (full | sb.ld_req);
   assign sb.empty = (count_q == '0);

   always_comb begin
      valid_d = valid_q;
      adr_d   = adr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PW'(1);
      end
      if (st_acc) begin
         valid_d[tail_q] = 1'b1;
         adr_d[tail_q]   = sb.adr;
         data_d[tail_q]  = sb.wdata;
         tail_d          = tail_q + PW'(1);
      end
      case ({st_acc, drain})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         adr_q   <= '0;
         data_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         adr_q   <= adr_d;
         data_q  <= data_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule
